// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: register width, tap mask, checker states and the feedback function.
// Generator and checker both call lfsr_feedback so the polynomial is defined in one place.
package lfsr_pkg;
  localparam int LFSR_WIDTH = 8;
  localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } chk_state_t;

  function automatic logic lfsr_feedback(input logic [LFSR_WIDTH-1:0] state,
                                         input logic [LFSR_WIDTH-1:0] taps);
    return ^(state & taps);
  endfunction
endpackage

// File: rtl/lfsr_sat_counter.sv
// Saturating up-counter with synchronous clear; an increment in the same cycle as a clear yields 1.
// Latency 1 cycle from inc/clr to count; no backpressure.
module lfsr_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);
  logic [W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (inc) begin
      if (clr)                count_q <= W'(1);
      else if (count_q != '1) count_q <= count_q + W'(1);
    end else if (clr) begin
      count_q <= '0;
    end
  end

  assign count = count_q;
endmodule

// File: rtl/lfsr_checker.sv
// Serial PRBS checker: self-synchronises, locks after LOCK_CNT good predictions, then counts bit errors.
// bit_error has 1-cycle latency; enable=0 freezes all state. Optional LFSR_CHK_ZERO_DETECT_EN adds dead-line detection.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int               WIDTH      = LFSR_WIDTH,
  parameter logic [WIDTH-1:0] TAPS       = LFSR_TAPS,
  parameter int               LOCK_CNT   = 8,
  parameter int               UNLOCK_ERR = 4,
  parameter int               ERR_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             seq_in,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             err_clr,
  output logic             locked,
  output logic             bit_error,
  output logic [ERR_W-1:0] error_count,
  output logic             stuck_zero
);
  localparam int FILL_W  = $clog2(WIDTH) + 1;
  localparam int MATCH_W = $clog2(LOCK_CNT) + 1;
  localparam int RUN_W   = $clog2(UNLOCK_ERR) + 1;

  chk_state_t         state_q, state_d;
  logic [WIDTH-1:0]   ref_q, ref_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic [MATCH_W-1:0] good_q, good_d;
  logic [RUN_W-1:0]   errrun_q, errrun_d;
  logic               bit_error_q;
  logic               pred, mismatch, err_inc;
`ifdef LFSR_CHK_ZERO_DETECT_EN
  logic               zero_hit, zero_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SEARCH;
      ref_q       <= '0;
      fill_q      <= '0;
      match_q     <= '0;
      good_q      <= '0;
      errrun_q    <= '0;
      bit_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ref_q       <= ref_d;
      fill_q      <= fill_d;
      match_q     <= match_d;
      good_q      <= good_d;
      errrun_q    <= errrun_d;
      bit_error_q <= err_inc;
    end
  end

  always_comb begin
    state_d  = state_q;
    ref_d    = ref_q;
    fill_d   = fill_q;
    match_d  = match_q;
    good_d   = good_q;
    errrun_d = errrun_q;
    err_inc  = 1'b0;
`ifdef LFSR_CHK_ZERO_DETECT_EN
    zero_hit = 1'b0;
`endif
    pred     = lfsr_feedback(ref_q, TAPS);
    mismatch = seq_in ^ pred;

    if (load) begin
      ref_d    = load_data;
      state_d  = VERIFY;
      fill_d   = '0;
      match_d  = '0;
      good_d   = '0;
      errrun_d = '0;
    end else if (enable) begin
      case (state_q)
        SEARCH: begin
          ref_d = {ref_q[WIDTH-2:0], seq_in};
          if (fill_q == FILL_W'(WIDTH - 1)) begin
            state_d = VERIFY;
            fill_d  = '0;
            match_d = '0;
          end else begin
            fill_d = fill_q + FILL_W'(1);
          end
        end
        VERIFY: begin
          ref_d = {ref_q[WIDTH-2:0], seq_in};
          if (mismatch) begin
            match_d = '0;
          end else if (match_q == MATCH_W'(LOCK_CNT - 1)) begin
            state_d  = LOCKED;
            match_d  = '0;
            good_d   = '0;
            errrun_d = '0;
          end else begin
            match_d = match_q + MATCH_W'(1);
          end
        end
        LOCKED: begin
          // Free-run on the prediction so a channel error never corrupts the reference.
          ref_d = {ref_q[WIDTH-2:0], pred};
          if (mismatch) begin
            err_inc = 1'b1;
            good_d  = '0;
            if (errrun_q == RUN_W'(UNLOCK_ERR - 1)) begin
              state_d  = SEARCH;
              fill_d   = '0;
              errrun_d = '0;
            end else begin
              errrun_d = errrun_q + RUN_W'(1);
            end
          end else if (good_q == MATCH_W'(LOCK_CNT - 1)) begin
            good_d   = '0;
            errrun_d = '0;
          end else begin
            good_d = good_q + MATCH_W'(1);
          end
        end
        default: state_d = SEARCH;
      endcase
`ifdef LFSR_CHK_ZERO_DETECT_EN
      if (state_q != SEARCH && ref_d == '0) begin
        zero_hit = 1'b1;
        state_d  = SEARCH;
        fill_d   = '0;
        match_d  = '0;
      end
`endif
    end
  end

`ifdef LFSR_CHK_ZERO_DETECT_EN
  always_ff @(posedge clk) begin
    if (rst || load) zero_q <= 1'b0;
    else if (zero_hit) zero_q <= 1'b1;
  end
  assign stuck_zero = zero_q;
`else
  assign stuck_zero = 1'b0;
`endif

  lfsr_sat_counter #(.W(ERR_W)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (err_inc),
    .clr   (err_clr),
    .count (error_count)
  );

  assign locked    = (state_q == LOCKED);
  assign bit_error = bit_error_q;
endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: a reference PRBS generator drives the stream, expectations are hand-derived.
module tb_lfsr_checker;
  logic        clk = 1'b0;
  logic        rst, enable, seq_in, load, err_clr;
  logic [7:0]  load_data;
  logic        locked, bit_error, stuck_zero;
  logic [15:0] error_count;

  int          total = 0;
  int          bad   = 0;
  logic [7:0]  g;
  logic        seen;

`ifdef LFSR_CHK_ZERO_DETECT_EN
  localparam bit ZD = 1'b1;
`else
  localparam bit ZD = 1'b0;
`endif

  always #5 clk = ~clk;

  lfsr_checker dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .seq_in      (seq_in),
    .load        (load),
    .load_data   (load_data),
    .err_clr     (err_clr),
    .locked      (locked),
    .bit_error   (bit_error),
    .error_count (error_count),
    .stuck_zero  (stuck_zero)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One bit of x^8+x^6+x^5+x^4+1 PRBS, optionally inverted; en=0 presents a gap with junk data.
  task automatic send(input logic flip, input logic en);
    logic b;
    if (en) begin
      b      = ^(g & 8'hB8);
      seq_in = b ^ flip;
      g      = {g[6:0], b};
      enable = 1'b1;
    end else begin
      enable = 1'b0;
      seq_in = 1'($urandom);
    end
    tick();
    seen = seen | bit_error;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; load = 1'b0; err_clr = 1'b0; seq_in = 1'b0; load_data = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    seen = 1'b0;
    do_reset();
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_bit_error", 32'(bit_error), 32'd0);
    check("rst_error_count", 32'(error_count), 32'd0);
    check("rst_stuck_zero", 32'(stuck_zero), 32'd0);

    // Clean lock from seed 0x01
    g = 8'h01;
    for (int i = 0; i < 15; i++) send(1'b0, 1'b1);
    check("clean_not_locked_15", 32'(locked), 32'd0);
    send(1'b0, 1'b1);
    check("clean_locked_16", 32'(locked), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) send(1'b0, 1'b1);
    check("clean_no_bit_error", 32'(seen), 32'd0);
    check("clean_error_count", 32'(error_count), 32'd0);
    check("clean_still_locked", 32'(locked), 32'd1);

    // Single inverted bit
    send(1'b1, 1'b1);
    check("single_pulse", 32'(bit_error), 32'd1);
    send(1'b0, 1'b1);
    check("single_pulse_end", 32'(bit_error), 32'd0);
    check("single_count", 32'(error_count), 32'd1);
    check("single_locked", 32'(locked), 32'd1);
    for (int i = 0; i < 10; i++) send(1'b0, 1'b1);
    err_clr = 1'b1;
    send(1'b0, 1'b1);
    err_clr = 1'b0;
    check("clr_count", 32'(error_count), 32'd0);

    // Loss of lock: errors at offsets 0,1,3,5
    send(1'b1, 1'b1);
    send(1'b1, 1'b1);
    send(1'b0, 1'b1);
    send(1'b1, 1'b1);
    send(1'b0, 1'b1);
    check("loss_locked_before_4th", 32'(locked), 32'd1);
    send(1'b1, 1'b1);
    check("loss_unlocked_4th", 32'(locked), 32'd0);
    check("loss_count", 32'(error_count), 32'd4);
    for (int i = 0; i < 15; i++) send(1'b0, 1'b1);
    check("relock_not_yet", 32'(locked), 32'd0);
    send(1'b0, 1'b1);
    check("relock_16", 32'(locked), 32'd1);
    check("relock_count_kept", 32'(error_count), 32'd4);

    // Gapped enable from seed 0x49
    do_reset();
    g = 8'h49;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      send(1'b0, 1'b1);
      send(1'b0, 1'b0);
    end
    check("gap_not_locked_15", 32'(locked), 32'd0);
    send(1'b0, 1'b1);
    check("gap_locked_16", 32'(locked), 32'd1);
    send(1'b0, 1'b0);
    check("gap_held", 32'(locked), 32'd1);
    check("gap_no_bit_error", 32'(seen), 32'd0);
    check("gap_count", 32'(error_count), 32'd0);

    // Load with the generator's current state: lock after 8 bits
    load = 1'b1; load_data = g; enable = 1'b1; seq_in = 1'($urandom);
    tick();
    load = 1'b0;
    check("load_clears_locked", 32'(locked), 32'd0);
    for (int i = 0; i < 7; i++) send(1'b0, 1'b1);
    check("load_not_locked_7", 32'(locked), 32'd0);
    send(1'b0, 1'b1);
    check("load_locked_8", 32'(locked), 32'd1);

    // err_clr coincident with a mismatch
    send(1'b1, 1'b1);
    check("pre_clr_count", 32'(error_count), 32'd1);
    send(1'b0, 1'b1);
    err_clr = 1'b1;
    send(1'b1, 1'b1);
    err_clr = 1'b0;
    check("clr_vs_inc", 32'(error_count), 32'd1);
    check("clr_vs_inc_locked", 32'(locked), 32'd1);

    // Dead line
    do_reset();
    seq_in = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    check("zero_not_locked_15", 32'(locked), 32'd0);
    tick();
    check("zero_cycle_16", 32'(locked), ZD ? 32'd0 : 32'd1);
    for (int i = 0; i < 24; i++) tick();
    check("zero_locked_40", 32'(locked), ZD ? 32'd0 : 32'd1);
    check("zero_stuck", 32'(stuck_zero), ZD ? 32'd1 : 32'd0);
    check("zero_count", 32'(error_count), 32'd0);
    enable = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
